// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types and constants for the receive/transmit paths.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
// Module  : synchronizer
// Brief   : Two-flop synchronizer for asynchronous single-bit inputs.
// Revision: 1.0 - initial release
// ============================================================================
module synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic RESET,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_sync <= {2{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver with 3-sample majority vote, ready/valid
//           holding register, framing-error and overrun pulses.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int                 c_CNT_W    = $clog2(10 * CLKS_PER_BIT + 2);
    localparam logic [c_CNT_W-1:0] c_HALF_CNT = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_CPB      = c_CNT_W'(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic               w_rxd_s;
    logic               r_rxd_prev;
    logic [1:0]         r_warm;
    logic               r_armed;
    uart_state_t        r_state;
    uart_state_t        w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_sample_pt;
    logic [1:0]         r_vote;
    logic [2:0]         r_nbits;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_error;
    logic               r_overrun;

    logic w_in_frame;
    logic w_edge;
    logic w_decide;
    logic w_bit;
    logic w_complete;
    logic w_bad_stop;

    synchronizer #(
        .RESET_VALUE(1'b1)
    ) u_rxd_sync (
        .clk  (clk),
        .RESET(RESET),
        .i_d  (rxd),
        .o_q  (w_rxd_s)
    );

    // Arming waits until the synchronizer holds real pin data and the line
    // has been seen high, so a line already low at reset release never
    // looks like a start edge.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_rxd_prev <= 1'b1;
            r_warm     <= 2'd0;
            r_armed    <= 1'b0;
        end else begin
            r_rxd_prev <= w_rxd_s;
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end
            if (r_warm == 2'd2 && w_rxd_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_in_frame = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign w_edge     = (r_state == IDLE) && r_armed && r_rxd_prev && !w_rxd_s;
    assign w_decide   = w_in_frame && (r_cnt == r_sample_pt + c_ONE);
    assign w_bit      = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rxd_s) | (r_vote[1] & w_rxd_s);
    assign w_complete = (r_state == STOP) && w_decide && w_bit;
    assign w_bad_stop = (r_state == STOP) && w_decide && !w_bit;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_edge)   w_state_next = START;
            START:     if (w_decide) w_state_next = w_bit ? IDLE : DATA;
            DATA:      if (w_decide && r_nbits == 3'd7) w_state_next = STOP;
            STOP:      if (w_decide) w_state_next = w_bit ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (w_rxd_s)  w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // Sample point advances by one bit period after every decision, so the
    // votes are taken at S-1 and S and resolved with the live sample at S+1.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_cnt       <= '0;
            r_sample_pt <= '0;
            r_vote      <= 2'b00;
            r_nbits     <= 3'd0;
            r_shift     <= 8'h00;
        end else if (w_edge) begin
            r_cnt       <= '0;
            r_sample_pt <= c_HALF_CNT;
            r_nbits     <= 3'd0;
        end else if (w_in_frame) begin
            r_cnt <= r_cnt + c_ONE;
            if (r_cnt == r_sample_pt - c_ONE) begin
                r_vote[0] <= w_rxd_s;
            end
            if (r_cnt == r_sample_pt) begin
                r_vote[1] <= w_rxd_s;
            end
            if (w_decide) begin
                r_sample_pt <= r_sample_pt + c_CPB;
                if (r_state == DATA) begin
                    r_shift <= {w_bit, r_shift[7:1]};
                    r_nbits <= r_nbits + 3'd1;
                end
            end
        end
    end

    // A completion coinciding with acceptance refills the holding register.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_bad_stop;
            r_overrun     <= w_complete && r_rx_valid && !rx_ready;
            if (w_complete && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx at CLKS_PER_BIT = 16.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk      = 1'b0;
    logic       RESET    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_xfer   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    logic [7:0] last_data = 8'h00;

    int x0, f0, o0;
    int t0, rise, after_v;
    logic [7:0] rise_data;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         period;
        int         exp_xfer;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            n_xfer++;
            last_data = rx_data;
        end
        if (frame_error) n_ferr++;
        if (overrun)     n_ovr++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int period,
                              input int low_hold, input int gap);
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(d[i], period);
        drive_bit(stop, period);
        if (!stop) drive_bit(1'b0, low_hold);
        drive_bit(1'b1, gap);
    endtask

    task automatic snap();
        x0 = n_xfer;
        f0 = n_ferr;
        o0 = n_ovr;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h3C, 1'b1, 16, 1, 8'h3C, 0};
        vecs[1] = '{8'hA3, 1'b0, 16, 0, 8'h00, 1};
        vecs[2] = '{8'h7E, 1'b1, 16, 1, 8'h7E, 0};
        vecs[3] = '{8'hFF, 1'b1, 15, 1, 8'hFF, 0};
        vecs[4] = '{8'h00, 1'b1, 17, 1, 8'h00, 0};
        vecs[5] = '{8'h00, 1'b0, 16, 0, 8'h00, 1};
        vecs[6] = '{8'h81, 1'b1, 17, 1, 8'h81, 0};
        vecs[7] = '{8'hC5, 1'b1, 16, 1, 8'hC5, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_error", frame_error, 0);
        check("reset_overrun", overrun, 0);
        RESET = 1'b1;
        drive_bit(1'b1, 10);

        // 0x55 with cycle-exact rx_valid timing: pin fall + 3 = E, rise at E + S9 + 2
        snap();
        t0   = cyc;
        rise = -1;
        fork
            send_frame(8'h55, 1'b1, CPB, 0, 20);
            begin
                for (int k = 0; k < 400 && rise < 0; k++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        rise      = cyc;
                        rise_data = rx_data;
                    end
                end
                @(negedge clk);
                after_v = rx_valid;
            end
        join
        check("x55_rise_cycle", rise - t0, 3 + (CPB / 2 + 9 * CPB) + 2);
        check("x55_data", rise_data, 8'h55);
        check("x55_valid_one_cycle", after_v, 0);
        check("x55_no_ferr", n_ferr - f0, 0);

        // False start: 4 low cycles
        snap();
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check("false_start_xfer", n_xfer - x0, 0);
        check("false_start_ferr", n_ferr - f0, 0);

        for (int v = 0; v < 8; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].period, 40, 20);
            check($sformatf("vec%0d_xfer", v), n_xfer - x0, vecs[v].exp_xfer);
            check($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), n_ovr - o0, 0);
            if (vecs[v].exp_xfer > 0) check($sformatf("vec%0d_data", v), last_data, vecs[v].exp_data);
        end

        // Overrun: two back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        snap();
        send_frame(8'h41, 1'b1, CPB, 0, 0);
        send_frame(8'h42, 1'b1, CPB, 0, 20);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_kept", rx_data, 8'h41);
        check("ovr_no_xfer", n_xfer - x0, 0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_accept_xfer", n_xfer - x0, 1);
        check("ovr_accept_data", last_data, 8'h41);
        check("ovr_valid_dropped", rx_valid, 0);
        @(posedge clk);
        #1;

        // Reset mid-frame during data bit 4 of 0x99, with a byte held
        send_frame(8'h11, 1'b1, CPB, 0, 10);
        check("rst_pre_valid", rx_valid, 1);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h99 >> i), CPB);
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        RESET = 1'b0;
        #1;
        check("rst_async_valid", rx_valid, 0);
        check("rst_async_data", rx_data, 0);
        repeat (3) @(posedge clk);
        #1;
        RESET    = 1'b1;
        rx_ready = 1'b1;
        drive_bit(1'b1, 20);
        snap();
        send_frame(8'h0D, 1'b1, CPB, 0, 20);
        check("post_rst_xfer", n_xfer - x0, 1);
        check("post_rst_data", last_data, 8'h0D);

        // Line held low across reset release must not start a frame
        rxd = 1'b0;
        #3;
        RESET = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b1;
        snap();
        drive_bit(1'b0, 30);
        drive_bit(1'b1, 40);
        send_frame(8'h5A, 1'b1, CPB, 0, 20);
        check("low_rst_xfer", n_xfer - x0, 1);
        check("low_rst_data", last_data, 8'h5A);
        check("low_rst_ferr", n_ferr - f0, 0);

        // Randomized frames against the frame-level model
        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            logic       st;
            int         p, hold, gap;
            d    = 8'($urandom_range(0, 255));
            st   = ($urandom_range(0, 3) != 0);
            p    = $urandom_range(16, 17);
            hold = $urandom_range(1, 30);
            gap  = st ? $urandom_range(0, 6) : $urandom_range(2, 6);
            snap();
            send_frame(d, st, p, hold, gap);
            check($sformatf("rnd%0d_xfer", r), n_xfer - x0, st ? 1 : 0);
            check($sformatf("rnd%0d_ferr", r), n_ferr - f0, st ? 0 : 1);
            if (st) check($sformatf("rnd%0d_data", r), last_data, d);
        end
        drive_bit(1'b1, 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
